// File: rtl/generator.sv
// Free-running MII TX frame source: idle gap, start, payload, terminate.
// Define GEN_PRBS_PAYLOAD_EN for PRBS31 payload instead of byte ramp.
module generator #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = 1,
  parameter int IDLE_WORDS    = 4,
  parameter int PAYLOAD_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  i_rst,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl
);

  if (DATA_WIDTH != 64) begin : g_bad_dw
    $error("generator: DATA_WIDTH must be 64");
  end
  if (CTRL_WIDTH != 1) begin : g_bad_cw
    $error("generator: CTRL_WIDTH must be 1");
  end
  if (IDLE_WORDS < 1) begin : g_bad_iw
    $error("generator: IDLE_WORDS must be >= 1");
  end
  if (PAYLOAD_WORDS < 1) begin : g_bad_pw
    $error("generator: PAYLOAD_WORDS must be >= 1");
  end

  localparam int MAXW =
    (IDLE_WORDS > PAYLOAD_WORDS) ? IDLE_WORDS : PAYLOAD_WORDS;
  localparam int CW = $clog2(MAXW + 1);

  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_WORDS - 1);
  localparam logic [CW-1:0] PAY_LAST  = CW'(PAYLOAD_WORDS - 1);

  localparam logic [DATA_WIDTH-1:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [DATA_WIDTH-1:0] START_W = 64'hD5555555555555FB;
  localparam logic [DATA_WIDTH-1:0] TERM_W  = 64'h07070707070707FD;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_TERM
  } state_e;

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] pay_w;

`ifdef GEN_PRBS_PAYLOAD_EN
  logic [30:0] lfsr_q;
  logic [30:0] lfsr_d;

  // 64 serial PRBS31 steps unrolled; first bit lands in bit 0
  always_comb begin
    lfsr_d = lfsr_q;
    pay_w  = '0;
    for (int i = 0; i < 64; i++) begin
      pay_w[i] = lfsr_d[30] ^ lfsr_d[27];
      lfsr_d   = {lfsr_d[29:0], pay_w[i]};
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      lfsr_q <= 31'h7FFFFFFF;
    end else if (state_q == S_DATA) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic [7:0] bcnt_q;

  always_comb begin
    pay_w = '0;
    for (int j = 0; j < 8; j++) begin
      pay_w[8*j +: 8] = bcnt_q + 8'(j);
    end
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      bcnt_q <= '0;
    end else if (state_q == S_DATA) begin
      bcnt_q <= bcnt_q + 8'd8;
    end else begin
      bcnt_q <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      o_tx_data <= IDLE_W;
      o_tx_ctrl <= '1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          o_tx_data <= IDLE_W;
          o_tx_ctrl <= '1;
          if (cnt_q == IDLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_START: begin
          o_tx_data <= START_W;
          o_tx_ctrl <= '1;
          cnt_q     <= '0;
          state_q   <= S_DATA;
        end
        S_DATA: begin
          o_tx_data <= pay_w;
          o_tx_ctrl <= '0;
          if (cnt_q == PAY_LAST) begin
            cnt_q   <= '0;
            state_q <= S_TERM;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_TERM: begin
          o_tx_data <= TERM_W;
          o_tx_ctrl <= '1;
          cnt_q     <= '0;
          state_q   <= S_IDLE;
        end
        default: begin
          o_tx_data <= IDLE_W;
          o_tx_ctrl <= '1;
          cnt_q     <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generator.sv
// Scoreboard bench for generator: expected words queued per edge,
// compared one edge at a time against {ctrl, data}.
module tb_generator;

  localparam int IW     = 4;
  localparam int PW     = 8;
  localparam int PERIOD = IW + PW + 2;

  localparam logic [64:0] E_IDLE  = {1'b1, 64'h0707070707070707};
  localparam logic [64:0] E_START = {1'b1, 64'hD5555555555555FB};
  localparam logic [64:0] E_TERM  = {1'b1, 64'h07070707070707FD};

  logic        clk;
  logic        rst_n;
  logic [63:0] tx_data;
  logic [0:0]  tx_ctrl;

  int checks;
  int errors;
  int n_start;
  int n_data;
  int n_term;

  logic [64:0] exp_q[$];
  logic [30:0] m_lfsr;

  generator #(
    .DATA_WIDTH   (64),
    .CTRL_WIDTH   (1),
    .IDLE_WORDS   (IW),
    .PAYLOAD_WORDS(PW)
  ) dut (
    .clk      (clk),
    .i_rst    (rst_n),
    .o_tx_data(tx_data),
    .o_tx_ctrl(tx_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [64:0] obs,
                     input logic [64:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] next_payload(input int k);
    logic [63:0] w;
    logic        b;
    w = '0;
`ifdef GEN_PRBS_PAYLOAD_EN
    for (int i = 0; i < 64; i++) begin
      b      = m_lfsr[30] ^ m_lfsr[27];
      w[i]   = b;
      m_lfsr = {m_lfsr[29:0], b};
    end
`else
    for (int j = 0; j < 8; j++) begin
      w[8*j +: 8] = 8'((8 * k + j) % 256);
    end
`endif
    return w;
  endfunction

  // expected sequence from reset release, edges 1..n
  task automatic push_edges(input int n);
    int p;
    m_lfsr = 31'h7FFFFFFF;
    for (int e = 0; e < n; e++) begin
      p = e % PERIOD;
      if (p < IW)
        exp_q.push_back(E_IDLE);
      else if (p == IW)
        exp_q.push_back(E_START);
      else if (p == PERIOD - 1)
        exp_q.push_back(E_TERM);
      else
        exp_q.push_back({1'b0, next_payload(p - IW - 1)});
    end
  endtask

  task automatic run_edges(input string ph, input int n,
                           input int cnt_lim);
    logic [64:0] obs;
    logic [64:0] exp;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      obs = {tx_ctrl, tx_data};
      if (exp_q.size() == 0) begin
        chk($sformatf("%s_e%0d_noexp", ph, e), obs, 65'hx);
      end else begin
        exp = exp_q.pop_front();
        chk($sformatf("%s_e%0d", ph, e), obs, exp);
      end
      if (e <= cnt_lim) begin
        if (obs === E_START) n_start++;
        if (obs === E_TERM)  n_term++;
        if (obs[64] === 1'b0) n_data++;
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    n_start = 0;
    n_data  = 0;
    n_term  = 0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_hold", {tx_ctrl, tx_data}, E_IDLE);

    @(negedge clk);
    rst_n = 1'b1;
    push_edges(51);
    run_edges("run1", 51, 3 * PERIOD);
    chk("cnt_start", 65'(n_start), 65'd3);
    chk("cnt_data", 65'(n_data), 65'(3 * PW));
    chk("cnt_term", 65'(n_term), 65'd3);
    chk("q_empty1", 65'(exp_q.size()), 65'd0);

    // edge 51 showed payload word 3; abort between edges
    #4;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {tx_ctrl, tx_data}, E_IDLE);
    @(posedge clk);
    #1;
    chk("rst_held", {tx_ctrl, tx_data}, E_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    push_edges(2 * PERIOD + 6);
    run_edges("run2", 2 * PERIOD + 6, 0);
    chk("q_empty2", 65'(exp_q.size()), 65'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
